register_read_ports: RTL

- Read-side counterpart to the register-file write path.
- Holds the 32 architectural registers, which are loaded by the one-hot enable vector and data produced by the write side.
- Serves two simultaneous source-operand reads (rs1, rs2) through a valid/ready request channel, with registered outputs and write-to-read bypass.
- Sits between the decode stage (requester) and the execute stage (consumer).

---
 rtl/register_read_ports.sv | 103 ++++++++++
 1 files changed

// File: rtl/register_read_ports.sv
`default_nettype none
// ============================================================================
// Module      : register_read_ports
// Description : 32-entry architectural register file with two read ports
//               (rs1/rs2), a valid/ready request channel, a one-entry
//               registered output buffer and same-cycle write-to-read bypass.
// Revision    : 1.0  initial release
// ============================================================================
module register_read_ports #(
  parameter int XLEN    = 32,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] writeData,
  input  logic [31:0]     registerEnable,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic            rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;
  logic [XLEN-1:0] w_value1, w_value2;
  logic            w_accept;

  // The output buffer can take a new result when empty or being drained now.
  assign req_ready = !rd_valid_q || rd_ready;
  assign w_accept  = req_valid && req_ready;

  // Storage update: every enabled register loads the broadcast data; x0 may be hardwired.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (registerEnable[i] && !(ZERO_X0 && (i == 0))) begin
        regs_d[i] = writeData;
      end
    end
  end

  // Operand selection: x0 zero, then same-cycle forwarding, then stored contents.
  always_comb begin
    w_value1 = regs_q[rs1];
    if (ZERO_X0 && (rs1 == 5'd0)) begin
      w_value1 = '0;
    end else if (registerEnable[rs1]) begin
      w_value1 = writeData;
    end
    w_value2 = regs_q[rs2];
    if (ZERO_X0 && (rs2 == 5'd0)) begin
      w_value2 = '0;
    end else if (registerEnable[rs2]) begin
      w_value2 = writeData;
    end
  end

  // Output buffer: load on accept, drop valid on drain, otherwise hold the snapshot.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    if (w_accept) begin
      rd_valid_d = 1'b1;
      rdata1_d   = w_value1;
      rdata2_d   = w_value2;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear of storage and pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      rd_valid_q <= 1'b0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_valid_q <= rd_valid_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;

endmodule
`default_nettype wire
